reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer_if.sv | 21 ++
 rtl/reset_sequencer.sv | 122 ++++++++++++
 tb/tb_reset_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer and the blocks whose resets it releases.
interface reset_sequencer_if #(
  parameter int unsigned NUM_STAGES = 4
);
  logic                  sw_reset_req;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] stage_reset_n;
  logic                  seq_done;
  logic                  seq_error;
  logic                  busy;

  modport master (
    output sw_reset_req, stage_ack,
    input  stage_reset_n, seq_done, seq_error, busy
  );

  modport slave (
    input  sw_reset_req, stage_ack,
    output stage_reset_n, seq_done, seq_error, busy
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES active-low resets in order after a hold period, each gated by
// its stage ack (with timeout) and separated by a fixed gap.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned STAGE_GAP   = 4,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  reset_sequencer_if.slave   bus
);

  localparam int unsigned MAX_HG = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned MAX_C  = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
  localparam int unsigned CW     = $clog2(MAX_C) + 1;
  localparam int unsigned IW     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(ACK_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

  typedef enum logic [2:0] {
    S_HOLD,
    S_RELEASE,
    S_WAIT_ACK,
    S_GAP,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [NUM_STAGES-1:0] r_stage_n;
  logic                  r_done;
  logic                  r_error;
  logic                  r_busy;

  logic                  w_ack;
  logic [IW-1:0]         w_next_idx;
  logic [CW-1:0]         w_cnt_sat;

  assign w_ack      = bus.stage_ack[r_idx];
  assign w_next_idx = r_idx + 1'b1;
  assign w_cnt_sat  = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_HOLD;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_stage_n <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_busy    <= 1'b1;
    end else if (bus.sw_reset_req && (r_state != S_HOLD)) begin
      // Software re-sequence keeps the sticky error; only the hardware reset clears it.
      r_state   <= S_HOLD;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_stage_n <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      case (r_state)
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            r_stage_n[0] <= 1'b1;
            r_idx        <= '0;
            r_cnt        <= '0;
            r_state      <= S_WAIT_ACK;
          end else begin
            r_cnt <= w_cnt_sat;
          end
        end
        S_RELEASE: begin
          r_stage_n[r_idx] <= 1'b1;
          r_cnt            <= '0;
          r_state          <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // A timeout advances exactly like an accepted ack, leaving the stage released.
          if (w_ack || (r_cnt == TO_LAST)) begin
            if (!w_ack) r_error <= 1'b1;
            r_cnt <= '0;
            if (r_idx == IDX_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_GAP;
            end
          end else begin
            r_cnt <= w_cnt_sat;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_stage_n[w_next_idx] <= 1'b1;
            r_idx                 <= w_next_idx;
            r_cnt                 <= '0;
            r_state               <= S_WAIT_ACK;
          end else begin
            r_cnt <= w_cnt_sat;
          end
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: r_state <= S_HOLD;
      endcase
    end
  end

  assign bus.stage_reset_n = r_stage_n;
  assign bus.seq_done      = r_done;
  assign bus.seq_error     = r_error;
  assign bus.busy          = r_busy;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer at default parameters; edge numbers count
// rising edges after reset (or a software re-sequence) releases.
`timescale 1ps/1ps
module tb_reset_sequencer;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   edge_n;

  reset_sequencer_if #(.NUM_STAGES(4)) bus ();

  reset_sequencer #(
    .NUM_STAGES (4),
    .HOLD_CYCLES(8),
    .STAGE_GAP  (4),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
  endtask

  task automatic go_to(input int n);
    while (edge_n < n) tick();
  endtask

  // Called just after an edge: pulses reset low mid-cycle so the next edge is edge 1.
  task automatic restart(input logic [3:0] ack);
    reset = 1'b0;
    bus.stage_ack = ack;
    #5;
    reset = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    edge_n = 0;
    reset = 1'b0;
    bus.sw_reset_req = 1'b0;
    bus.stage_ack = 4'b1111;
    #20;
    chk("rst_stage", bus.stage_reset_n, 4'b0000);
    chk("rst_done",  bus.seq_done, 1'b0);
    chk("rst_err",   bus.seq_error, 1'b0);
    chk("rst_busy",  bus.busy, 1'b1);
    #5;
    reset = 1'b1;
    edge_n = 0;

    // Scenario 1: all acks present
    go_to(7);  chk("s1_e7",  bus.stage_reset_n, 4'b0000);
    go_to(8);  chk("s1_e8",  bus.stage_reset_n, 4'b0001);
    go_to(12); chk("s1_e12", bus.stage_reset_n, 4'b0001);
    go_to(13); chk("s1_e13", bus.stage_reset_n, 4'b0011);
    go_to(17); chk("s1_e17", bus.stage_reset_n, 4'b0011);
    go_to(18); chk("s1_e18", bus.stage_reset_n, 4'b0111);
    go_to(22); chk("s1_e22", bus.stage_reset_n, 4'b0111);
    go_to(23); chk("s1_e23", bus.stage_reset_n, 4'b1111);
               chk("s1_e23_done", bus.seq_done, 1'b0);
               chk("s1_e23_busy", bus.busy, 1'b1);
    go_to(24); chk("s1_e24_done", bus.seq_done, 1'b1);
               chk("s1_e24_busy", bus.busy, 1'b0);
               chk("s1_e24_err",  bus.seq_error, 1'b0);

    // Scenario 2: stage 1 never acks -> timeout
    restart(4'b1101);
    go_to(13); chk("s2_e13", bus.stage_reset_n, 4'b0011);
    go_to(28); chk("s2_e28_err", bus.seq_error, 1'b0);
    go_to(29); chk("s2_e29_err", bus.seq_error, 1'b1);
               chk("s2_e29", bus.stage_reset_n, 4'b0011);
    go_to(32); chk("s2_e32", bus.stage_reset_n, 4'b0011);
    go_to(33); chk("s2_e33", bus.stage_reset_n, 4'b0111);
    go_to(38); chk("s2_e38", bus.stage_reset_n, 4'b1111);
               chk("s2_e38_done", bus.seq_done, 1'b0);
    go_to(39); chk("s2_e39_done", bus.seq_done, 1'b1);
               chk("s2_e39_busy", bus.busy, 1'b0);
    go_to(42); chk("s2_e42_err", bus.seq_error, 1'b1);

    // Scenario 3: software re-sequence from DONE
    bus.stage_ack = 4'b1111;
    bus.sw_reset_req = 1'b1;
    tick();
    bus.sw_reset_req = 1'b0;
    edge_n = 0;
    chk("s3_stage", bus.stage_reset_n, 4'b0000);
    chk("s3_done",  bus.seq_done, 1'b0);
    chk("s3_busy",  bus.busy, 1'b1);
    chk("s3_err",   bus.seq_error, 1'b1);
    go_to(7);  chk("s3_e7", bus.stage_reset_n, 4'b0000);
    go_to(8);  chk("s3_e8", bus.stage_reset_n, 4'b0001);
    go_to(15); chk("s3_e15", bus.stage_reset_n, 4'b0011);
               chk("s3_e15_err", bus.seq_error, 1'b1);

    // Scenario 4: async reset mid-GAP, no clock edge in between
    #3;
    reset = 1'b0;
    #1;
    chk("s4_stage", bus.stage_reset_n, 4'b0000);
    chk("s4_err",   bus.seq_error, 1'b0);
    chk("s4_busy",  bus.busy, 1'b1);
    chk("s4_done",  bus.seq_done, 1'b0);
    #2;
    reset = 1'b1;
    edge_n = 0;

    // Scenario 5 folded into the re-run: sw request during HOLD is ignored
    go_to(3);
    bus.sw_reset_req = 1'b1;
    tick();
    bus.sw_reset_req = 1'b0;
    chk("s5_e4",  bus.stage_reset_n, 4'b0000);
    go_to(7);  chk("s5_e7",  bus.stage_reset_n, 4'b0000);
    go_to(8);  chk("s5_e8",  bus.stage_reset_n, 4'b0001);
    go_to(13); chk("s5_e13", bus.stage_reset_n, 4'b0011);
    go_to(18); chk("s5_e18", bus.stage_reset_n, 4'b0111);
    go_to(23); chk("s5_e23", bus.stage_reset_n, 4'b1111);
    go_to(24); chk("s5_e24_done", bus.seq_done, 1'b1);
               chk("s5_e24_err",  bus.seq_error, 1'b0);

    // Scenario 6: early ack0 not taken at the release edge; early ack2 ignored until idx=2
    restart(4'b0101);
    go_to(8);  chk("s6_e8",  bus.stage_reset_n, 4'b0001);
    go_to(12); chk("s6_e12", bus.stage_reset_n, 4'b0001);
    go_to(13); chk("s6_e13", bus.stage_reset_n, 4'b0011);
    bus.stage_ack = 4'b1111;
    go_to(17); chk("s6_e17", bus.stage_reset_n, 4'b0011);
    go_to(18); chk("s6_e18", bus.stage_reset_n, 4'b0111);
    go_to(22); chk("s6_e22", bus.stage_reset_n, 4'b0111);
    go_to(23); chk("s6_e23", bus.stage_reset_n, 4'b1111);
    go_to(24); chk("s6_e24_done", bus.seq_done, 1'b1);
               chk("s6_e24_err",  bus.seq_error, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
